seg_scan_capture: RTL and testbench



---
 rtl/seg_cap_pkg.sv | 32 +++
 rtl/seg7_pattern_decode.sv | 36 +++
 rtl/seg_scan_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_cap_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_cap_pkg                                                 |
// | Purpose  : Shared definitions for the 7-segment scan capture block:    |
// |            capture FSM state encoding, the 16-entry hex segment table  |
// |            (active-low g..a) and the blank pattern.                    |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package seg_cap_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment code for nibble n lives at [7n+6:7n].
  localparam logic [111:0] SEG_DECODE_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    return SEG_DECODE_TABLE[7*nib +: 7];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg7_pattern_decode                                         |
// | Purpose  : Combinational inverse of the hex 7-segment table. Maps an   |
// |            active-low g..a pattern back to its nibble.                 |
// | Ports    : pattern [6:0] in  - active-low segments g..a                |
// |            nibble  [3:0] out - recovered hex value (0 when not valid)  |
// |            valid         out - pattern is one of the 16 hex glyphs     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seg7_pattern_decode
  import seg_cap_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    // Table entries are unique, so at most one iteration matches.
    for (int i = 0; i < 16; i++) begin
      if (pattern == seg_code(4'(i))) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
    // The blank glyph is never in the table; kept explicit for clarity.
    if (pattern == SEG_BLANK) begin
      valid = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_scan_capture                                            |
// | Purpose  : Monitors a multiplexed active-low segment/digit bus of a    |
// |            common-anode display, recovers the hex value and decimal    |
// |            point per digit, and pulses frame_valid once every digit    |
// |            has been captured.                                          |
// | Ports    : sys_clk, sys_rst_n (async, active-low)                      |
// |            seg_in[7:0]      active-low segments, bit7 = dp             |
// |            dig_in[DIGITS-1:0] active-low one-hot digit select          |
// |            value[4*DIGITS-1:0] captured nibbles, digit k at [4k+3:4k]  |
// |            dp, digit_err    per-digit dp (active-high) / bad pattern   |
// |            frame_valid      one-cycle pulse per complete frame         |
// |            scan_lost        watchdog flag                              |
// | Options  : SEG_CAP_TIMEOUT_EN - enables the scan watchdog; without it  |
// |            scan_lost is tied low.                                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seg_scan_capture
  import seg_cap_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_in,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  scan_lost
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  if (DIGITS < 1 || DIGITS > 8 || STABLE_CYCLES < 2 || STABLE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("seg_scan_capture: parameter out of range");
  end

  // ---------------------------------------------------------------------
  // Input synchronisers; they idle at all-ones (dark display, no digit).
  // seg_prev/dig_prev hold the previous synchronised pair for change
  // detection and are also the settled pair used at capture time.
  // ---------------------------------------------------------------------
  logic [7:0]        seg_meta, seg_sync, seg_prev;
  logic [DIGITS-1:0] dig_meta, dig_sync, dig_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_meta <= '1;
      seg_sync <= '1;
      seg_prev <= '1;
      dig_meta <= '1;
      dig_sync <= '1;
      dig_prev <= '1;
    end else begin
      seg_meta <= seg_in;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      dig_meta <= dig_in;
      dig_sync <= dig_meta;
      dig_prev <= dig_sync;
    end
  end

  logic pair_changed;
  assign pair_changed = (seg_sync != seg_prev) || (dig_sync != dig_prev);

  // ---------------------------------------------------------------------
  // Settle FSM
  // ---------------------------------------------------------------------
  cap_state_t state;
  logic [7:0] stable_cnt;
  logic [7:0] cnt_next;

  assign cnt_next = stable_cnt + 8'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_WAIT;
      stable_cnt <= 8'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (pair_changed) begin
            stable_cnt <= 8'd0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (pair_changed) begin
            stable_cnt <= 8'd0;
          end else begin
            stable_cnt <= cnt_next;
            if (cnt_next == CNT_LAST) begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          stable_cnt <= 8'd0;
          state      <= ST_WAIT;
        end
        default: begin
          stable_cnt <= 8'd0;
          state      <= ST_WAIT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Capture qualification: exactly one active (low) digit select.
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] dig_act;
  logic              single_digit;
  logic              capture_en;

  assign dig_act      = ~dig_prev;
  assign single_digit = (dig_act != '0) &&
                        ((dig_act & (dig_act - DIGITS'(1))) == '0);
  assign capture_en   = (state == ST_CAPTURE) && single_digit;

  logic [3:0] pat_nibble;
  logic       pat_valid;

  seg7_pattern_decode u_decode (
    .pattern (seg_prev[6:0]),
    .nibble  (pat_nibble),
    .valid   (pat_valid)
  );

  // ---------------------------------------------------------------------
  // Per-digit result slots
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] val_q;
    logic       dp_q;
    logic       err_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        val_q <= 4'h0;
        dp_q  <= 1'b0;
        err_q <= 1'b0;
      end else if (capture_en && dig_act[k]) begin
        if (pat_valid) begin
          val_q <= pat_nibble;
          dp_q  <= ~seg_prev[7];
          err_q <= 1'b0;
        end else begin
          // Unrecognised glyph: keep the last good value and dp.
          err_q <= 1'b1;
        end
      end
    end

    assign value[4*k +: 4] = val_q;
    assign dp[k]           = dp_q;
    assign digit_err[k]    = err_q;
  end

  // ---------------------------------------------------------------------
  // Frame tracking (and optional scan watchdog)
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] cap_mask;
  logic              seen_full;

  assign cap_mask  = capture_en ? dig_act : '0;
  assign seen_full = &seen;

`ifdef SEG_CAP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  assign wd_expire = (wd_cnt == WD_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_cnt    <= '0;
      scan_lost <= 1'b0;
    end else if (frame_valid) begin
      wd_cnt    <= '0;
      scan_lost <= 1'b0;
    end else if (wd_expire) begin
      wd_cnt    <= '0;
      scan_lost <= 1'b1;
    end else begin
      wd_cnt    <= wd_cnt + WD_W'(1);
    end
  end
`else
  logic wd_expire;
  assign wd_expire = 1'b0;
  assign scan_lost = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seen        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= seen_full;
      if (wd_expire) begin
        seen <= '0;
      end else begin
        // A capture landing on the completion cycle starts the next frame.
        seen <= (seen_full ? '0 : seen) | cap_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_seg_scan_capture                                         |
// | Purpose  : Directed self-checking bench for seg_scan_capture           |
// |            (DIGITS=8, STABLE_CYCLES=4, TIMEOUT_CYCLES=100).            |
// | Options  : SEG_CAP_TIMEOUT_EN - adds the watchdog scenario.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_seg_scan_capture;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg   = 8'hFF;
  logic [7:0]  dig   = 8'hFF;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  digit_err;
  logic        frame_valid;
  logic        scan_lost;

  int checks   = 0;
  int errors   = 0;
  int fv_count = 0;

  seg_scan_capture #(
    .DIGITS         (8),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .seg_in      (seg),
    .dig_in      (dig),
    .value       (value),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_lost   (scan_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_count <= fv_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int k, input logic [7:0] s, input int hold);
    logic [7:0] one;
    one = 8'd1;
    dig = ~(one << k);
    seg = s;
    tick(hold);
  endtask

  task automatic idle(input int n);
    dig = 8'hFF;
    seg = 8'hFF;
    tick(n);
  endtask

  // Hex glyph with dp dark, active-low.
  function automatic logic [7:0] seg_byte(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // {valid, nibble} for a 7-bit active-low pattern.
  function automatic logic [4:0] model_dec(input logic [6:0] p);
    case (p)
      7'h40: return 5'h10;  7'h79: return 5'h11;  7'h24: return 5'h12;  7'h30: return 5'h13;
      7'h19: return 5'h14;  7'h12: return 5'h15;  7'h02: return 5'h16;  7'h78: return 5'h17;
      7'h00: return 5'h18;  7'h10: return 5'h19;  7'h08: return 5'h1A;  7'h03: return 5'h1B;
      7'h46: return 5'h1C;  7'h21: return 5'h1D;  7'h06: return 5'h1E;  7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  initial begin
    int         fv0;
    logic [3:0] exp_nib;
    logic       exp_err;
    logic [4:0] d;
    logic [3:0] scan_vals [8];

    // Reset state
    tick(3);
    chk("rst_value", value, 32'h0);
    chk("rst_dp", dp, 8'h00);
    chk("rst_err", digit_err, 8'h00);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_lost", scan_lost, 1'b0);
    rst_n = 1'b1;

    // Idle buses
    fv0 = fv_count;
    idle(1000);
    chk("idle_frames", fv_count - fv0, 0);
    chk("idle_value", value, 32'h0);
    chk("idle_dp", dp, 8'h00);
    chk("idle_err", digit_err, 8'h00);
`ifndef SEG_CAP_TIMEOUT_EN
    chk("idle_lost", scan_lost, 1'b0);
`endif

    // Scan 1..8
    fv0 = fv_count;
    for (int k = 0; k < 8; k++) show(k, seg_byte(4'(k + 1)), 10);
    idle(20);
    chk("scan_value", value, 32'h87654321);
    chk("scan_dp", dp, 8'h00);
    chk("scan_err", digit_err, 8'h00);
`ifndef SEG_CAP_TIMEOUT_EN
    chk("scan_frames", fv_count - fv0, 1);
`endif

    // Digit 3: A with dp, then blank
    show(3, 8'h08, 10);
    chk("a_value", value, 32'h8765A321);
    chk("a_dp", dp, 8'h08);
    chk("a_err", digit_err, 8'h00);
    show(3, 8'hFF, 10);
    chk("blank_err", digit_err, 8'h08);
    chk("blank_value", value, 32'h8765A321);
    chk("blank_dp", dp, 8'h08);
    idle(20);

    // Glitch: digit 5 held only 2 cycles
    dig = 8'hDF;
    seg = 8'hC0;
    tick(2);
    idle(20);
    chk("glitch_value", value, 32'h8765A321);
    chk("glitch_err", digit_err, 8'h08);
    chk("glitch_dp", dp, 8'h08);

    // Two digits selected at once
    dig = 8'hFC;
    seg = 8'hC0;
    tick(10);
    idle(20);
    chk("multi_value", value, 32'h8765A321);
    chk("multi_err", digit_err, 8'h08);
    chk("multi_dp", dp, 8'h08);

    // Partial scan, then reset mid-settle
    show(0, seg_byte(4'h9), 10);
    show(1, seg_byte(4'hB), 10);
    show(2, seg_byte(4'hC), 10);
    show(3, seg_byte(4'hD), 10);
    show(4, seg_byte(4'hE), 10);
    chk("part_value", value, 32'h876EDCB9);
    chk("part_dp", dp, 8'h00);
    chk("part_err", digit_err, 8'h00);
    show(5, 8'hC0, 4);
    rst_n = 1'b0;
    #2;
    chk("mrst_value", value, 32'h0);
    chk("mrst_dp", dp, 8'h00);
    chk("mrst_err", digit_err, 8'h00);
    chk("mrst_fv", frame_valid, 1'b0);
    idle(2);
    rst_n = 1'b1;
    tick(5);

    // Full scan after reset: F,E,d,C,b,A,9,0 with dp on digit 7
    scan_vals[0] = 4'hF; scan_vals[1] = 4'hE; scan_vals[2] = 4'hD; scan_vals[3] = 4'hC;
    scan_vals[4] = 4'hB; scan_vals[5] = 4'hA; scan_vals[6] = 4'h9; scan_vals[7] = 4'h0;
    fv0 = fv_count;
    for (int k = 0; k < 7; k++) show(k, seg_byte(scan_vals[k]), 10);
    show(7, seg_byte(scan_vals[7]) & 8'h7F, 10);
    idle(20);
    chk("post_value", value, 32'h09ABCDEF);
    chk("post_dp", dp, 8'h80);
    chk("post_err", digit_err, 8'h00);
`ifndef SEG_CAP_TIMEOUT_EN
    chk("post_frames", fv_count - fv0, 1);
`endif

    // Every 7-bit pattern on digit 0
    exp_nib = 4'hF;
    exp_err = 1'b0;
    for (int p = 0; p < 128; p++) begin
      show(0, {1'b1, 7'(p)}, 10);
      d = model_dec(7'(p));
      if (d[4]) begin
        exp_nib = d[3:0];
        exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
      chk($sformatf("sweep_val_%02h", p), value[3:0], exp_nib);
      chk($sformatf("sweep_err_%02h", p), digit_err[0], exp_err);
    end
    chk("sweep_dp", dp, 8'h80);
    chk("sweep_upper", value[31:4], 28'h09ABCDE);
    idle(20);

`ifdef SEG_CAP_TIMEOUT_EN
    begin
      int w;
      w = 0;
      while (scan_lost !== 1'b1 && w < 300) begin
        tick(1);
        w++;
      end
      chk("wd_lost_set", scan_lost, 1'b1);
      fv0 = fv_count;
      for (int k = 0; k < 8; k++) show(k, seg_byte(4'(k + 1)), 10);
      idle(5);
      chk("wd_frames", fv_count - fv0, 1);
      chk("wd_lost_clear", scan_lost, 1'b0);
      chk("wd_value", value, 32'h87654321);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
